camara_captura: RTL and testbench

- Parametrised OV7670-class capture front end. Generates the camera master clock Xclk by division of clk and samples Vsync/Href/Pclk/Imagen in the clk domain.
- Assembles 1- or 2-byte pixels, writes them with linear addresses to a frame-buffer RAM write port, and reports frame completion and framing errors.
- Sits between the camera pins and the frame-buffer RAM.

---
 rtl/camara_captura.sv | 202 ++++++++++++++++++++
 tb/tb_camara_captura.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/camara_captura.sv
// OV7670-class capture front end: Xclk generation, pin synchronisation,
// byte-to-pixel assembly and linear frame-buffer writes with framing checks.
module camara_captura #(
  parameter int unsigned XCLK_DIV        = 2,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned ADDR_W          = 19
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         Vsync,
  input  logic                         Href,
  input  logic                         Pclk,
  input  logic [7:0]                   Imagen,
  input  logic                         capture_en,
  output logic                         Xclk,
  output logic                         Cam_PWDN,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [8*BYTES_PER_PIXEL-1:0] wr_data,
  output logic                         frame_done,
  output logic                         busy,
  output logic [15:0]                  frame_cnt,
  output logic                         err_overrun,
  output logic                         err_short
);

  localparam int unsigned DIV_W = ($clog2(XCLK_DIV) > 0) ? $clog2(XCLK_DIV) : 1;
  localparam int unsigned X_W   = $clog2(H_ACTIVE + 1);
  localparam int unsigned Y_W   = $clog2(V_ACTIVE + 1);
  localparam int unsigned PIX_W = 8 * BYTES_PER_PIXEL;

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DONE} state_t;

  state_t state, state_nx;

  logic [DIV_W-1:0]  div_cnt;
  logic [2:0]        vs_s, hr_s, pc_s;
  logic [7:0]        im_s0, im_s1;
  logic              byte_stb_q, hr_rise_q, hr_fall_q, vs_rise_q, vs_fall_q;
  logic [7:0]        data_q, first_byte;
  logic              phase, line_has_byte;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr_ptr, line_base;

  logic              phase_c, start_c, done_entry_c, active_c, busy_c;
  logic [PIX_W-1:0]  pixel_c;

  assign Cam_PWDN = 1'b0;

  // Free-running master clock divider
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
      Xclk    <= 1'b0;
    end else if (div_cnt == DIV_W'(XCLK_DIV - 1)) begin
      div_cnt <= '0;
      Xclk    <= ~Xclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Two-flop synchronisers, third flop for edges, then one registered event stage
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      vs_s       <= '0;
      hr_s       <= '0;
      pc_s       <= '0;
      im_s0      <= '0;
      im_s1      <= '0;
      byte_stb_q <= 1'b0;
      hr_rise_q  <= 1'b0;
      hr_fall_q  <= 1'b0;
      vs_rise_q  <= 1'b0;
      vs_fall_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      vs_s       <= {vs_s[1:0], Vsync};
      hr_s       <= {hr_s[1:0], Href};
      pc_s       <= {pc_s[1:0], Pclk};
      im_s0      <= Imagen;
      im_s1      <= im_s0;
      byte_stb_q <= pc_s[1] & ~pc_s[2] & hr_s[1];
      hr_rise_q  <= hr_s[1] & ~hr_s[2];
      hr_fall_q  <= ~hr_s[1] & hr_s[2];
      vs_rise_q  <= vs_s[1] & ~vs_s[2];
      vs_fall_q  <= ~vs_s[1] & vs_s[2];
      data_q     <= im_s1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (capture_en) state_nx = WAIT_VS;
      WAIT_VS: begin
        if (!capture_en)    state_nx = IDLE;
        else if (vs_fall_q) state_nx = ACTIVE;
      end
      ACTIVE:  if (vs_rise_q) state_nx = DONE;
      DONE:    state_nx = capture_en ? WAIT_VS : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start_c      = 1'b0;
    done_entry_c = 1'b0;
    active_c     = 1'b0;
    busy_c       = 1'b0;
    if (state == WAIT_VS && state_nx == ACTIVE) start_c = 1'b1;
    if (state == ACTIVE && state_nx == DONE)    done_entry_c = 1'b1;
    if (state == ACTIVE)                        active_c = 1'b1;
    if (state_nx == WAIT_VS || state_nx == ACTIVE) busy_c = 1'b1;
  end

  // A line start on the same cycle as a byte must still see phase 0
  always_comb begin
    phase_c = phase & ~hr_rise_q;
    if (BYTES_PER_PIXEL == 2) pixel_c = PIX_W'({first_byte, data_q});
    else                      pixel_c = PIX_W'(data_q);
  end

  // Pixel assembly, addressing and framing error tracking
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      frame_cnt     <= '0;
      err_overrun   <= 1'b0;
      err_short     <= 1'b0;
      first_byte    <= '0;
      phase         <= 1'b0;
      line_has_byte <= 1'b0;
      x             <= '0;
      y             <= '0;
      addr_ptr      <= '0;
      line_base     <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= done_entry_c;
      busy       <= busy_c;
      if (done_entry_c) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (y < Y_W'(V_ACTIVE)) err_short <= 1'b1;
      end
      if (start_c) begin
        x             <= '0;
        y             <= '0;
        addr_ptr      <= '0;
        line_base     <= '0;
        phase         <= 1'b0;
        line_has_byte <= 1'b0;
      end else if (active_c) begin
        if (hr_fall_q) begin
          x             <= '0;
          phase         <= 1'b0;
          line_has_byte <= 1'b0;
          if (phase_c) err_short <= 1'b1;
          if (x != '0 && x < X_W'(H_ACTIVE)) err_short <= 1'b1;
          if (line_has_byte) begin
            if (y < Y_W'(V_ACTIVE)) y <= y + Y_W'(1);
            line_base <= line_base + ADDR_W'(H_ACTIVE);
            addr_ptr  <= line_base + ADDR_W'(H_ACTIVE);
          end
        end else begin
          if (hr_rise_q) phase <= 1'b0;
          if (byte_stb_q) begin
            line_has_byte <= 1'b1;
            if (BYTES_PER_PIXEL == 2 && !phase_c) begin
              first_byte <= data_q;
              phase      <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (x < X_W'(H_ACTIVE) && y < Y_W'(V_ACTIVE)) begin
                wr_en    <= 1'b1;
                wr_addr  <= addr_ptr;
                wr_data  <= pixel_c;
                addr_ptr <= addr_ptr + ADDR_W'(1);
                x        <= x + X_W'(1);
              end else begin
                err_overrun <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_camara_captura.sv
// Scoreboard bench for camara_captura on a reduced 4x2 frame, 2 bytes per pixel.
module tb_camara_captura;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned AW = 19;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          Reset;
  logic          Vsync, Href, Pclk, capture_en;
  logic [7:0]    Imagen;
  logic          Xclk, Cam_PWDN, wr_en, frame_done, busy, err_overrun, err_short;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [15:0]   frame_cnt;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   exp_frames = 0;
  int   my = 0;
  logic exp_overrun = 1'b0;
  logic exp_short   = 1'b0;

  camara_captura #(
    .XCLK_DIV(2), .H_ACTIVE(H), .V_ACTIVE(V), .BYTES_PER_PIXEL(2), .ADDR_W(AW)
  ) dut (
    .clk(clk), .Reset(Reset), .Vsync(Vsync), .Href(Href), .Pclk(Pclk),
    .Imagen(Imagen), .capture_en(capture_en), .Xclk(Xclk), .Cam_PWDN(Cam_PWDN),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .busy(busy), .frame_cnt(frame_cnt), .err_overrun(err_overrun), .err_short(err_short)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every write the DUT issues must match the oldest expected write
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    Imagen = b;
    wait_clk(2);
    Pclk = 1'b1;
    wait_clk(3);
    Pclk = 1'b0;
    wait_clk(1);
  endtask

  task automatic start_frame();
    my = 0;
    Vsync = 1'b1;
    wait_clk(8);
    Vsync = 1'b0;
    wait_clk(8);
  endtask

  // Model the line, queue its expected writes, then drive it
  task automatic send_line(input int nbytes, input logic [7:0] b0);
    int npix;
    exp_t e;
    npix = nbytes / 2;
    if (nbytes % 2 != 0) exp_short = 1'b1;
    if (npix > 0 && npix < int'(H)) exp_short = 1'b1;
    for (int p = 0; p < npix; p++) begin
      if (p < int'(H) && my < int'(V)) begin
        e.addr = AW'(my * int'(H) + p);
        e.data = {8'(int'(b0) + 2 * p), 8'(int'(b0) + 2 * p + 1)};
        exp_q.push_back(e);
      end else begin
        exp_overrun = 1'b1;
      end
    end
    if (nbytes > 0) my++;
    Href = 1'b1;
    wait_clk(4);
    for (int i = 0; i < nbytes; i++) cam_byte(8'(int'(b0) + i));
    wait_clk(2);
    Href = 1'b0;
    wait_clk(6);
  endtask

  task automatic end_frame();
    if (my < int'(V)) exp_short = 1'b1;
    exp_frames++;
    Vsync = 1'b1;
    wait_clk(12);
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("done_pulses", 32'(done_cnt), 32'(exp_frames));
    check("err_overrun", 32'(err_overrun), 32'(exp_overrun));
    check("err_short", 32'(err_short), 32'(exp_short));
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    Vsync = 1'b0;
    Href = 1'b0;
    Pclk = 1'b0;
    Imagen = 8'h00;
    capture_en = 1'b0;
    wait_clk(4);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_xclk", 32'(Xclk), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    Reset = 1'b0;

    // Xclk toggles every second clk edge after reset release
    for (int k = 1; k <= 8; k++) begin
      wait_clk(1);
      check("xclk", 32'(Xclk), 32'((k / 2) % 2));
    end
    check("pwdn", 32'(Cam_PWDN), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_errs", 32'({err_overrun, err_short, frame_done}), 32'd0);

    capture_en = 1'b1;
    wait_clk(4);
    check("wait_vs_busy", 32'(busy), 32'd1);

    // Clean frame: bytes 0x01..0x10
    start_frame();
    send_line(8, 8'h01);
    send_line(8, 8'h09);
    end_frame();

    // Overlong first line, second line still starts at address H
    start_frame();
    send_line(10, 8'h21);
    send_line(8, 8'h41);
    end_frame();

    // Odd byte count line and a frame one line short
    start_frame();
    send_line(7, 8'h61);
    end_frame();

    // capture_en dropped mid-frame: frame still completes, then idle
    start_frame();
    send_line(8, 8'h81);
    capture_en = 1'b0;
    send_line(8, 8'h91);
    end_frame();
    check("idle_after_drop", 32'(busy), 32'd0);

    // Reset in the middle of a line aborts with no write and no frame_done
    capture_en = 1'b1;
    wait_clk(4);
    start_frame();
    Href = 1'b1;
    wait_clk(4);
    cam_byte(8'hAA);
    Imagen = 8'hBB;
    Pclk = 1'b1;
    wait_clk(1);
    Reset = 1'b1;
    wait_clk(1);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_errs", 32'({err_overrun, err_short}), 32'd0);
    wait_clk(3);
    Pclk = 1'b0;
    Href = 1'b0;
    capture_en = 1'b0;
    Reset = 1'b0;
    wait_clk(20);
    check("abort_no_done", 32'(done_cnt), 32'(exp_frames));
    check("abort_cnt_hold", 32'(frame_cnt), 32'd0);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
